line_render_scheduler: RTL and testbench

Sequences per-line rendering of the three line-buffer producers (layer 0, layer 1, sprites) that feed the composer. Each time the composer requests a line, the block latches the line index and the enables. It then starts the enabled renderers one at a time, so only one renderer owns the VRAM fetch path at any moment. It toggles the line-buffer bank, enforces a per-unit watchdog, and aborts an unfinished line when the next request arrives.

---
 rtl/line_render_scheduler.sv | 163 ++++++++++++++++
 tb/tb_line_render_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_render_scheduler.sv
// Purpose : sequences the per-line renderers (layer 0, layer 1, sprites) one at a
//           time, flips the line-buffer bank per line and watchdogs each unit.
// Latency : request -> first unit start 1 cycle; done -> next start 1 cycle.
// Backpressure: none; a new request pre-empts (aborts) an unfinished line.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   line_render_start, line_idx        composer request + line index
//   layer0/layer1/sprites_enabled      unit enables, sampled with the request
//   render_line_idx, render_bank       latched line index / bank being written
//   display_bank                       bank being displayed (!render_bank)
//   l0/l1/spr_start, _done, _abort     per-unit handshake pulses
//   busy, line_done, line_overrun, unit_timeout   status pulses/levels
module line_render_scheduler #(
  parameter int TIMEOUT_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_render_start,
  input  logic [8:0] line_idx,
  input  logic       layer0_enabled,
  input  logic       layer1_enabled,
  input  logic       sprites_enabled,
  output logic [8:0] render_line_idx,
  output logic       render_bank,
  output logic       display_bank,
  output logic       l0_start,
  output logic       l1_start,
  output logic       spr_start,
  input  logic       l0_done,
  input  logic       l1_done,
  input  logic       spr_done,
  output logic       l0_abort,
  output logic       l1_abort,
  output logic       spr_abort,
  output logic       busy,
  output logic       line_done,
  output logic       line_overrun,
  output logic       unit_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Encoding is deliberate: for a unit state, its value equals the index of the
  // unit that follows it (L0=1 -> next is unit 1, SPR=3 -> no unit left).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L0   = 2'd1,
    ST_L1   = 2'd2,
    ST_SPR  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       en_q, en_d;
  logic [8:0]       idx_q, idx_d;
  logic             bank_q, bank_d;
  logic             line_done_q, line_done_d;
  logic             overrun_q, overrun_d;
  logic [2:0]       abort_q, abort_d;

  logic       unit_active;
  logic       first_cycle;
  logic       cur_done;
  logic       done_ok;
  logic       wd_fire;
  logic [2:0] cur_onehot;
  logic [1:0] next_from;

  // First enabled unit with index >= from, in the fixed order L0, L1, SPR.
  function automatic state_e pick_unit(input logic [2:0] en, input logic [1:0] from);
    if (from == 2'd0 && en[0]) return ST_L0;
    if (from <= 2'd1 && en[1]) return ST_L1;
    if (from <= 2'd2 && en[2]) return ST_SPR;
    return ST_IDLE;
  endfunction

  assign unit_active = (state_q != ST_IDLE);
  // The counter is cleared on every unit entry, so zero marks the start cycle.
  assign first_cycle = (cnt_q == '0);
  assign next_from   = state_q;
  assign cur_onehot  = {state_q == ST_SPR, state_q == ST_L1, state_q == ST_L0};
  assign cur_done    = |(cur_onehot & {spr_done, l1_done, l0_done});

  // A done arriving together with the start pulse belongs to a previous run.
  assign done_ok = unit_active && !first_cycle && cur_done;
  // Done wins over expiry; a new request handles the abort itself (overrun).
  assign wd_fire = unit_active && (cnt_q == CNT_LAST) && !done_ok && !line_render_start;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    line_done_d = 1'b0;
    overrun_d   = 1'b0;
    abort_d     = 3'b000;

    if (line_render_start) begin
      if (unit_active) begin
        abort_d   = cur_onehot;
        overrun_d = 1'b1;
      end
      en_d    = {sprites_enabled, layer1_enabled, layer0_enabled};
      idx_d   = line_idx;
      bank_d  = ~bank_q;
      state_d = pick_unit(en_d, 2'd0);
      cnt_d   = '0;
      if (state_d == ST_IDLE) line_done_d = 1'b1;
    end else if (done_ok || wd_fire) begin
      state_d = pick_unit(en_q, next_from);
      cnt_d   = '0;
      if (state_d == ST_IDLE) line_done_d = 1'b1;
    end else if (unit_active) begin
      // Cannot wrap: reaching CNT_LAST always leaves the state.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      en_q        <= 3'b000;
      idx_q       <= 9'd0;
      bank_q      <= 1'b0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
    end
  end

  assign render_line_idx = idx_q;
  assign render_bank     = bank_q;
  assign display_bank    = ~bank_q;

  assign l0_start  = (state_q == ST_L0)  && first_cycle;
  assign l1_start  = (state_q == ST_L1)  && first_cycle;
  assign spr_start = (state_q == ST_SPR) && first_cycle;

  // Overrun aborts are registered (cycle after the request); watchdog aborts
  // appear in the expiry cycle itself so the next unit can start right after.
  assign l0_abort  = abort_q[0] | (wd_fire && state_q == ST_L0);
  assign l1_abort  = abort_q[1] | (wd_fire && state_q == ST_L1);
  assign spr_abort = abort_q[2] | (wd_fire && state_q == ST_SPR);

  assign busy         = unit_active;
  assign line_done    = line_done_q;
  assign line_overrun = overrun_q;
  assign unit_timeout = wd_fire;

endmodule

// File: tb/tb_line_render_scheduler.sv
// Purpose : self-checking bench for line_render_scheduler against a unit/age model.
// Latency : one model step per clock; outputs sampled 1 time unit after negedge.
// Backpressure: n/a (bench drives the unit done pulses itself).
module tb_line_render_scheduler;

  localparam int T = 16;

  logic       clk;
  logic       rst_n;
  logic       line_render_start;
  logic [8:0] line_idx;
  logic       layer0_enabled, layer1_enabled, sprites_enabled;
  logic [8:0] render_line_idx;
  logic       render_bank, display_bank;
  logic       l0_start, l1_start, spr_start;
  logic       l0_done, l1_done, spr_done;
  logic       l0_abort, l1_abort, spr_abort;
  logic       busy, line_done, line_overrun, unit_timeout;

  line_render_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .line_render_start(line_render_start),
    .line_idx         (line_idx),
    .layer0_enabled   (layer0_enabled),
    .layer1_enabled   (layer1_enabled),
    .sprites_enabled  (sprites_enabled),
    .render_line_idx  (render_line_idx),
    .render_bank      (render_bank),
    .display_bank     (display_bank),
    .l0_start         (l0_start),
    .l1_start         (l1_start),
    .spr_start        (spr_start),
    .l0_done          (l0_done),
    .l1_done          (l1_done),
    .spr_done         (spr_done),
    .l0_abort         (l0_abort),
    .l1_abort         (l1_abort),
    .spr_abort        (spr_abort),
    .busy             (busy),
    .line_done        (line_done),
    .line_overrun     (line_overrun),
    .unit_timeout     (unit_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which unit is rendering (0..2, 3 = none), how many cycles
  // since its start, plus the pulses owed in the following cycle.
  int       m_cur;
  int       m_age;
  bit [2:0] m_en;
  bit [8:0] m_idx;
  bit       m_bank;
  bit       m_pdone, m_povr;
  bit [2:0] m_pab;
  int       rsp_delay [3];   // done after this many cycles in the unit; -1 = never
  int       n_line_done, n_abort, n_timeout;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 3; m_age = 0; m_en = 3'b000; m_idx = 9'd0; m_bank = 1'b0;
    m_pdone = 1'b0; m_povr = 1'b0; m_pab = 3'b000;
  endtask

  function automatic int next_unit(input bit [2:0] en, input int from);
    for (int i = from; i < 3; i++) if (en[i]) return i;
    return 3;
  endfunction

  function automatic logic [2:0] auto_done();
    logic [2:0] d = 3'b000;
    if (m_cur < 3 && rsp_delay[m_cur] >= 0 && m_age == rsp_delay[m_cur]) d[m_cur] = 1'b1;
    return d;
  endfunction

  // One clock: drive inputs, compare every output with the model, advance model.
  task automatic step(input logic req, input logic [8:0] li, input logic [2:0] en,
                      input logic [2:0] dn);
    logic [2:0] d;
    logic [2:0] es, ea;
    bit done_ok, wd;
    @(negedge clk);
    d = dn | auto_done();
    line_render_start = req; line_idx = li;
    {sprites_enabled, layer1_enabled, layer0_enabled} = en;
    {spr_done, l1_done, l0_done} = d;
    #1;
    done_ok = (m_cur < 3) && (m_age > 0) && d[m_cur];
    wd      = (m_cur < 3) && (m_age == T - 1) && !done_ok && !req;
    es = 3'b000; ea = m_pab;
    if (m_cur < 3 && m_age == 0) es[m_cur] = 1'b1;
    if (wd) ea[m_cur] = 1'b1;
    chk("start",        16'({spr_start, l1_start, l0_start}), 16'(es));
    chk("abort",        16'({spr_abort, l1_abort, l0_abort}), 16'(ea));
    chk("unit_timeout", 16'(unit_timeout), 16'(wd));
    chk("line_done",    16'(line_done),    16'(m_pdone));
    chk("line_overrun", 16'(line_overrun), 16'(m_povr));
    chk("busy",         16'(busy),         16'(m_cur < 3));
    chk("line_idx",     16'(render_line_idx), 16'(m_idx));
    chk("render_bank",  16'(render_bank),  16'(m_bank));
    chk("display_bank", 16'(display_bank), 16'(!m_bank));
    n_line_done += int'(line_done);
    n_abort     += int'(l0_abort) + int'(l1_abort) + int'(spr_abort);
    n_timeout   += int'(unit_timeout);
    // advance model
    m_pdone = 1'b0; m_povr = 1'b0; m_pab = 3'b000;
    if (req) begin
      if (m_cur < 3) begin m_pab[m_cur] = 1'b1; m_povr = 1'b1; end
      m_en = en; m_idx = li; m_bank = !m_bank;
      m_cur = next_unit(m_en, 0); m_age = 0;
      if (m_cur == 3) m_pdone = 1'b1;
    end else if (done_ok || wd) begin
      m_cur = next_unit(m_en, m_cur + 1); m_age = 0;
      if (m_cur == 3) m_pdone = 1'b1;
    end else if (m_cur < 3) begin
      m_age++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 3'b000, 3'b000);
  endtask

  task automatic clr_counts();
    n_line_done = 0; n_abort = 0; n_timeout = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    line_render_start = 1'b0; line_idx = 9'd0;
    layer0_enabled = 1'b0; layer1_enabled = 1'b0; sprites_enabled = 1'b0;
    l0_done = 1'b0; l1_done = 1'b0; spr_done = 1'b0;
    rsp_delay[0] = 10; rsp_delay[1] = 10; rsp_delay[2] = 10;
    model_reset();
    clr_counts();
    #12;
    chk("rst_busy",   16'(busy), 16'd0);
    chk("rst_bank",   16'(render_bank), 16'd0);
    chk("rst_dbank",  16'(display_bank), 16'd1);
    chk("rst_idx",    16'(render_line_idx), 16'd0);
    chk("rst_starts", 16'({spr_start, l1_start, l0_start}), 16'd0);
    rst_n = 1'b1;

    // All units enabled, line 37, each done 10 cycles after its start.
    step(1'b1, 9'd37, 3'b111, 3'b000);
    idle(40);
    chk("s1_line_done_cnt", 16'(n_line_done), 16'd1);
    chk("s1_abort_cnt",     16'(n_abort), 16'd0);
    chk("s1_idx",           16'(render_line_idx), 16'd37);
    chk("s1_bank",          16'(render_bank), 16'd1);

    // Only sprites, then nothing enabled.
    step(1'b1, 9'd5, 3'b100, 3'b000);
    idle(15);
    clr_counts();
    step(1'b1, 9'd9, 3'b000, 3'b000);
    idle(3);
    chk("none_line_done_cnt", 16'(n_line_done), 16'd1);

    // Layer 1 never finishes: watchdog skips it, sprites still run.
    rsp_delay[1] = -1;
    clr_counts();
    step(1'b1, 9'd20, 3'b111, 3'b000);
    idle(50);
    chk("wd_timeout_cnt",   16'(n_timeout), 16'd1);
    chk("wd_line_done_cnt", 16'(n_line_done), 16'd1);

    // Overrun during L1 by line 38.
    rsp_delay[1] = 10;
    clr_counts();
    step(1'b1, 9'd37, 3'b111, 3'b000);
    idle(15);
    step(1'b1, 9'd38, 3'b111, 3'b000);
    idle(40);
    chk("ovr_line_done_cnt", 16'(n_line_done), 16'd1);
    chk("ovr_idx",           16'(render_line_idx), 16'd38);

    // Stray dones: l0_done with the start pulse, l0_done while in L1,
    // and done exactly at the watchdog expiry cycle.
    rsp_delay[0] = 20;
    step(1'b1, 9'd40, 3'b111, 3'b000);
    step(1'b0, 9'd0, 3'b000, 3'b001);
    idle(22);
    step(1'b0, 9'd0, 3'b000, 3'b001);
    step(1'b0, 9'd0, 3'b000, 3'b001);
    idle(30);
    rsp_delay[0] = T - 1; rsp_delay[1] = T - 1; rsp_delay[2] = T - 1;
    clr_counts();
    step(1'b1, 9'd41, 3'b111, 3'b000);
    idle(3 * T + 5);
    chk("race_timeout_cnt", 16'(n_timeout), 16'd0);
    chk("race_abort_cnt",   16'(n_abort), 16'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic req;
      req = ($urandom_range(0, 49) == 0);
      if (req) for (int u = 0; u < 3; u++) begin
        int r;
        r = int'($urandom_range(0, 20));
        rsp_delay[u] = (r == 20) ? -1 : r;
      end
      step(req, 9'($urandom), 3'($urandom),
           ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000);
    end
    idle(3 * T + 5);

    // Asynchronous reset in the middle of the sprite unit.
    rsp_delay[0] = 5; rsp_delay[1] = 5; rsp_delay[2] = -1;
    step(1'b1, 9'd77, 3'b111, 3'b000);
    idle(16);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   16'(busy), 16'd0);
    chk("mid_rst_bank",   16'(render_bank), 16'd0);
    chk("mid_rst_dbank",  16'(display_bank), 16'd1);
    chk("mid_rst_idx",    16'(render_line_idx), 16'd0);
    chk("mid_rst_aborts", 16'({spr_abort, l1_abort, l0_abort}), 16'd0);
    chk("mid_rst_starts", 16'({spr_start, l1_start, l0_start}), 16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_delay[2] = 5;
    step(1'b1, 9'd7, 3'b111, 3'b000);
    step(1'b0, 9'd0, 3'b000, 3'b000);
    chk("post_rst_bank", 16'(render_bank), 16'd1);
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
